// File: rtl/fft_radix2_core_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fft_radix2_core_pkg
// Description : Shared widths, FSM encodings and twiddle ROM generator for the
//               iterative radix-2 FFT core.
// Revision    : 1.0 - initial release
// ============================================================================
package fft_radix2_core_pkg;

    localparam int N_DEFAULT = 16;
    localparam int DATA_W    = 32;
    localparam int TW_W      = 14;
    localparam int TW_FRAC   = 12;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_LOAD  = 4'd1,
        ST_READ  = 4'd2,
        ST_CALC  = 4'd3,
        ST_WRITE = 4'd4,
        ST_OUT   = 4'd5
    } state_t;

    localparam real PI = 3.14159265358979323846;

    // Round half away from zero into a signed Q1.12 twiddle word.
    function automatic logic [TW_W-1:0] tw_round(input real v);
        int i;
        if (v >= 0.0) i = $rtoi(v + 0.5);
        else          i = -$rtoi(0.5 - v);
        return TW_W'(i);
    endfunction

    // Returns {re, im} of exp(-j*2*pi*k/n) scaled by 2^TW_FRAC.
    function automatic logic [2*TW_W-1:0] twiddle(input int k, input int n);
        real ang;
        real scale;
        ang   = 2.0 * PI * $itor(k) / $itor(n);
        scale = $itor(1 << TW_FRAC);
        return {tw_round(scale * $cos(ang)), tw_round(-scale * $sin(ang))};
    endfunction

endpackage
`default_nettype wire

// File: rtl/fft_radix2_core_butterfly.sv
`default_nettype none
// ============================================================================
// Module      : fft_butterfly_unit
// Description : Combinational radix-2 DIT butterfly, t = (x1*w) >>> 12,
//               y0 = x0 + t, y1 = x0 - t, 32-bit wrap-around.
// Revision    : 1.0 - initial release
// ============================================================================
module fft_butterfly_unit
    import fft_radix2_core_pkg::*;
(
    input  logic [DATA_W-1:0] i_x0_re,
    input  logic [DATA_W-1:0] i_x0_im,
    input  logic [DATA_W-1:0] i_x1_re,
    input  logic [DATA_W-1:0] i_x1_im,
    input  logic [TW_W-1:0]   i_w_re,
    input  logic [TW_W-1:0]   i_w_im,
    output logic [DATA_W-1:0] o_y0_re,
    output logic [DATA_W-1:0] o_y0_im,
    output logic [DATA_W-1:0] o_y1_re,
    output logic [DATA_W-1:0] o_y1_im
);

    localparam int PROD_W = DATA_W + TW_W;
    localparam int SUM_W  = PROD_W + 1;

    logic signed [PROD_W-1:0] w_p_rr, w_p_ii, w_p_ri, w_p_ir;
    logic signed [SUM_W-1:0]  w_t_re_full, w_t_im_full;
    logic [DATA_W-1:0]        w_t_re, w_t_im;

    always_comb begin
        w_p_rr = PROD_W'($signed(i_x1_re)) * PROD_W'($signed(i_w_re));
        w_p_ii = PROD_W'($signed(i_x1_im)) * PROD_W'($signed(i_w_im));
        w_p_ri = PROD_W'($signed(i_x1_re)) * PROD_W'($signed(i_w_im));
        w_p_ir = PROD_W'($signed(i_x1_im)) * PROD_W'($signed(i_w_re));

        w_t_re_full = SUM_W'(w_p_rr) - SUM_W'(w_p_ii);
        w_t_im_full = SUM_W'(w_p_ri) + SUM_W'(w_p_ir);

        // Arithmetic shift floors toward -inf; upper bits simply wrap away.
        w_t_re = DATA_W'(w_t_re_full >>> TW_FRAC);
        w_t_im = DATA_W'(w_t_im_full >>> TW_FRAC);

        o_y0_re = i_x0_re + w_t_re;
        o_y0_im = i_x0_im + w_t_im;
        o_y1_re = i_x0_re - w_t_re;
        o_y1_im = i_x0_im - w_t_im;
    end

endmodule
`default_nettype wire

// File: rtl/fft_radix2_core.sv
`default_nettype none
// ============================================================================
// Module      : fft_radix2_core
// Description : Iterative in-place radix-2 DIT FFT: bit-reversed load, log2(N)
//               stages of 3-cycle butterflies, natural-order pair readout.
// Revision    : 1.0 - initial release
// ============================================================================
module fft_radix2_core
    import fft_radix2_core_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [DATA_W-1:0]        x0_re_i,
    input  logic [DATA_W-1:0]        x0_im_i,
    input  logic [DATA_W-1:0]        x1_re_i,
    input  logic [DATA_W-1:0]        x1_im_i,
    input  logic                     start_i,
    output logic                     fft_ready_o,
    output logic [DATA_W-1:0]        x0_re_o,
    output logic [DATA_W-1:0]        x0_im_o,
    output logic [DATA_W-1:0]        x1_re_o,
    output logic [DATA_W-1:0]        x1_im_o,
    output logic [DATA_W-1:0]        x0_re_ram,
    output logic [DATA_W-1:0]        x0_im_ram,
    output logic [DATA_W-1:0]        x1_re_ram,
    output logic [DATA_W-1:0]        x1_im_ram,
    output logic [DATA_W-1:0]        X0_re_bf,
    output logic [DATA_W-1:0]        X0_im_bf,
    output logic [DATA_W-1:0]        X1_re_bf,
    output logic [DATA_W-1:0]        X1_im_bf,
    output logic [TW_W-1:0]          w_re,
    output logic [TW_W-1:0]          w_im,
    output logic [$clog2(N)-1:0]     bram_addr_x0,
    output logic [$clog2(N)-1:0]     bram_addr_x1,
    output logic [$clog2(N/2)-1:0]   twiddle_addr,
    output logic                     bram_x0_en,
    output logic                     bram_x1_en,
    output logic [3:0]               state
);

    localparam int LOG2N = $clog2(N);
    localparam int AW    = LOG2N;
    localparam int TWA_W = LOG2N - 1;

    state_t            r_state;
    logic              r_start_d;
    logic [AW-1:0]     r_load_cnt;
    logic [3:0]        r_stage;
    logic [TWA_W-1:0]  r_bfly;
    logic [TWA_W-1:0]  r_out_cnt;

    logic [DATA_W-1:0] r_mem_re [N];
    logic [DATA_W-1:0] r_mem_im [N];

    logic [TW_W-1:0]   w_rom_re [N/2];
    logic [TW_W-1:0]   w_rom_im [N/2];

    logic [AW-1:0]     w_bfly_ext, w_span, w_pos, w_a0, w_a1, w_out_a0, w_out_a1;
    logic [TWA_W-1:0]  w_tw_addr;
    logic [TW_W-1:0]   w_tw_re, w_tw_im;
    logic              w_in_bfly, w_load_we;
    logic [DATA_W-1:0] w_y0_re, w_y0_im, w_y1_re, w_y1_im;
    logic              w_unused;

    assign w_unused = ^{x1_re_i, x1_im_i};

    for (genvar k = 0; k < N/2; k++) begin : g_tw_rom
        localparam logic [2*TW_W-1:0] c_tw = twiddle(k, N);
        assign w_rom_re[k] = c_tw[2*TW_W-1:TW_W];
        assign w_rom_im[k] = c_tw[TW_W-1:0];
    end

    // Butterfly b of stage s pairs a0 (b with a 0 inserted at bit s) and a0+2^s.
    always_comb begin
        w_bfly_ext = AW'(r_bfly);
        w_span     = AW'(1) << r_stage;
        w_pos      = w_bfly_ext & (w_span - AW'(1));
        w_a0       = ((w_bfly_ext >> r_stage) << (r_stage + 4'd1)) | w_pos;
        w_a1       = w_a0 | w_span;
        w_tw_addr  = TWA_W'(w_pos << (4'(LOG2N - 1) - r_stage));
        w_tw_re    = w_rom_re[w_tw_addr];
        w_tw_im    = w_rom_im[w_tw_addr];
        w_out_a0   = {r_out_cnt, 1'b0};
        w_out_a1   = {r_out_cnt, 1'b1};
        w_in_bfly  = (r_state == ST_READ) || (r_state == ST_CALC) || (r_state == ST_WRITE);
        w_load_we  = r_start_d && ((r_state == ST_IDLE) || (r_state == ST_LOAD));
    end

    always_comb begin
        bram_addr_x0 = '0;
        bram_addr_x1 = '0;
        twiddle_addr = '0;
        w_re         = '0;
        w_im         = '0;
        if (w_in_bfly) begin
            bram_addr_x0 = w_a0;
            bram_addr_x1 = w_a1;
            twiddle_addr = w_tw_addr;
            w_re         = w_tw_re;
            w_im         = w_tw_im;
        end else if (r_state == ST_OUT) begin
            bram_addr_x0 = w_out_a0;
            bram_addr_x1 = w_out_a1;
        end
        bram_x0_en = (r_state == ST_READ) || (r_state == ST_WRITE) || (r_state == ST_OUT);
        bram_x1_en = bram_x0_en;
        state      = r_state;
    end

    fft_butterfly_unit u_bfly (
        .i_x0_re (x0_re_ram),
        .i_x0_im (x0_im_ram),
        .i_x1_re (x1_re_ram),
        .i_x1_im (x1_im_ram),
        .i_w_re  (w_tw_re),
        .i_w_im  (w_tw_im),
        .o_y0_re (w_y0_re),
        .o_y0_im (w_y0_im),
        .o_y1_re (w_y1_re),
        .o_y1_im (w_y1_im)
    );

    // Sample storage is intentionally left uncleared by reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            if (w_load_we) begin
                r_mem_re[r_load_cnt] <= x0_re_i;
                r_mem_im[r_load_cnt] <= x0_im_i;
            end else if (r_state == ST_WRITE) begin
                r_mem_re[w_a0] <= X0_re_bf;
                r_mem_im[w_a0] <= X0_im_bf;
                r_mem_re[w_a1] <= X1_re_bf;
                r_mem_im[w_a1] <= X1_im_bf;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            r_state     <= ST_IDLE;
            r_start_d   <= 1'b0;
            r_load_cnt  <= '0;
            r_stage     <= '0;
            r_bfly      <= '0;
            r_out_cnt   <= '0;
            fft_ready_o <= 1'b0;
            x0_re_o     <= '0;
            x0_im_o     <= '0;
            x1_re_o     <= '0;
            x1_im_o     <= '0;
            x0_re_ram   <= '0;
            x0_im_ram   <= '0;
            x1_re_ram   <= '0;
            x1_im_ram   <= '0;
            X0_re_bf    <= '0;
            X0_im_bf    <= '0;
            X1_re_bf    <= '0;
            X1_im_bf    <= '0;
        end else begin
            r_start_d   <= start_i && ((r_state == ST_IDLE) || (r_state == ST_LOAD));
            fft_ready_o <= (r_state == ST_OUT);
            case (r_state)
                ST_IDLE: begin
                    if (r_start_d) begin
                        r_load_cnt <= AW'(1);
                        r_state    <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (r_start_d) begin
                        r_load_cnt <= r_load_cnt + AW'(1);
                        if (r_load_cnt == AW'(N - 1)) begin
                            r_stage <= '0;
                            r_bfly  <= '0;
                            r_state <= ST_READ;
                        end
                    end
                end
                ST_READ: begin
                    x0_re_ram <= r_mem_re[w_a0];
                    x0_im_ram <= r_mem_im[w_a0];
                    x1_re_ram <= r_mem_re[w_a1];
                    x1_im_ram <= r_mem_im[w_a1];
                    r_state   <= ST_CALC;
                end
                ST_CALC: begin
                    X0_re_bf <= w_y0_re;
                    X0_im_bf <= w_y0_im;
                    X1_re_bf <= w_y1_re;
                    X1_im_bf <= w_y1_im;
                    r_state  <= ST_WRITE;
                end
                ST_WRITE: begin
                    if (r_bfly == TWA_W'(N/2 - 1)) begin
                        r_bfly <= '0;
                        if (r_stage == 4'(LOG2N - 1)) begin
                            r_stage   <= '0;
                            r_out_cnt <= '0;
                            r_state   <= ST_OUT;
                        end else begin
                            r_stage <= r_stage + 4'd1;
                            r_state <= ST_READ;
                        end
                    end else begin
                        r_bfly  <= r_bfly + TWA_W'(1);
                        r_state <= ST_READ;
                    end
                end
                ST_OUT: begin
                    x0_re_o   <= r_mem_re[w_out_a0];
                    x0_im_o   <= r_mem_im[w_out_a0];
                    x1_re_o   <= r_mem_re[w_out_a1];
                    x1_im_o   <= r_mem_im[w_out_a1];
                    r_out_cnt <= r_out_cnt + TWA_W'(1);
                    if (r_out_cnt == TWA_W'(N/2 - 1)) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fft_radix2_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_fft_radix2_core
// Description : Scoreboard bench for fft_radix2_core with directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fft_radix2_core;

    localparam int N = 16;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic        start_i = 1'b0;
    logic [31:0] x0_re_i = '0, x0_im_i = '0, x1_re_i = '0, x1_im_i = '0;
    logic        fft_ready_o;
    logic [31:0] x0_re_o, x0_im_o, x1_re_o, x1_im_o;
    logic [31:0] x0_re_ram, x0_im_ram, x1_re_ram, x1_im_ram;
    logic [31:0] X0_re_bf, X0_im_bf, X1_re_bf, X1_im_bf;
    logic [13:0] w_re, w_im;
    logic [3:0]  bram_addr_x0, bram_addr_x1;
    logic [2:0]  twiddle_addr;
    logic        bram_x0_en, bram_x1_en;
    logic [3:0]  state;

    typedef struct {
        int re0; int im0; int re1; int im1; int tol;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_errors = 0;
    int   samp_re [N];
    int   samp_im [N];
    int   exp_re  [N];
    int   exp_im  [N];
    int   tone_tbl [N] = '{4096, 3784, 2896, 1567, 0, -1567, -2896, -3784,
                           -4096, -3784, -2896, -1567, 0, 1567, 2896, 3784};
    time  t_start, t_rise;

    fft_radix2_core #(.N(N)) dut (
        .clk(clk), .rstn(rstn),
        .x0_re_i(x0_re_i), .x0_im_i(x0_im_i), .x1_re_i(x1_re_i), .x1_im_i(x1_im_i),
        .start_i(start_i), .fft_ready_o(fft_ready_o),
        .x0_re_o(x0_re_o), .x0_im_o(x0_im_o), .x1_re_o(x1_re_o), .x1_im_o(x1_im_o),
        .x0_re_ram(x0_re_ram), .x0_im_ram(x0_im_ram), .x1_re_ram(x1_re_ram), .x1_im_ram(x1_im_ram),
        .X0_re_bf(X0_re_bf), .X0_im_bf(X0_im_bf), .X1_re_bf(X1_re_bf), .X1_im_bf(X1_im_bf),
        .w_re(w_re), .w_im(w_im),
        .bram_addr_x0(bram_addr_x0), .bram_addr_x1(bram_addr_x1), .twiddle_addr(twiddle_addr),
        .bram_x0_en(bram_x0_en), .bram_x1_en(bram_x1_en), .state(state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp, input int tol);
        n_checks++;
        if (act > exp + tol || act < exp - tol) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (tol %0d) at %0t", name, act, exp, tol, $time);
        end
    endtask

    function automatic int bitrev4(input int v);
        int r = 0;
        for (int b = 0; b < 4; b++) if (v[b]) r |= 1 << (3 - b);
        return r;
    endfunction

    // Expected spectrum (natural order) becomes N/2 scoreboard pairs.
    task automatic push_expected(input int tol);
        exp_t e;
        for (int k = 0; k < N/2; k++) begin
            e.re0 = exp_re[2*k];   e.im0 = exp_im[2*k];
            e.re1 = exp_re[2*k+1]; e.im1 = exp_im[2*k+1];
            e.tol = tol;
            sb_q.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        if (fft_ready_o) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_output: got fft_ready_o=1, expected no pending pair");
            end else begin
                mon_e = sb_q.pop_front();
                check("out_x0_re", x0_re_o, mon_e.re0, mon_e.tol);
                check("out_x0_im", x0_im_o, mon_e.im0, mon_e.tol);
                check("out_x1_re", x1_re_o, mon_e.re1, mon_e.tol);
                check("out_x1_im", x1_im_o, mon_e.im1, mon_e.tol);
            end
        end
    end

    task automatic load_samples(output time t0);
        t0 = 0;
        @(negedge clk);
        start_i = 1'b1;
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            if (i == 0) t0 = $time;
            x0_re_i = samp_re[i];
            x0_im_i = samp_im[i];
            if (i == N - 1) start_i = 1'b0;
        end
    endtask

    task automatic wait_done(output time tr);
        int rdy_cnt = 0;
        bit seen = 1'b0;
        bit done = 1'b0;
        tr = 0;
        for (int c = 0; c < 400 && !done; c++) begin
            @(negedge clk);
            if (fft_ready_o) begin
                if (!seen) tr = $time;
                seen = 1'b1;
                rdy_cnt++;
            end else if (seen) begin
                done = 1'b1;
            end
        end
        check("run_completed", int'(done), 1, 0);
        check("ready_cycles", rdy_cnt, N/2, 0);
        check("idle_after_out", int'(state), 0, 0);
        check("scoreboard_drained", sb_q.size(), 0, 0);
    endtask

    task automatic set_impulse();
        for (int i = 0; i < N; i++) begin
            samp_re[i] = (bitrev4(i) == 0) ? 1000 : 0;
            samp_im[i] = 0;
            exp_re[i]  = 1000;
            exp_im[i]  = 0;
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        check("rst_state", int'(state), 0, 0);
        check("rst_ready", int'(fft_ready_o), 0, 0);
        check("rst_en", int'(bram_x0_en), 0, 0);
        check("rst_w_re", int'(w_re), 0, 0);

        // Impulse
        set_impulse();
        push_expected(0);
        load_samples(t_start);
        wait_done(t_rise);

        // DC with timing and an ignored start pulse during compute
        for (int i = 0; i < N; i++) begin
            samp_re[i] = 100; samp_im[i] = 0;
            exp_re[i] = (i == 0) ? 1600 : 0; exp_im[i] = 0;
        end
        push_expected(0);
        load_samples(t_start);
        @(negedge clk); check("step_read", int'(state), 2, 0);
        @(negedge clk); check("step_calc", int'(state), 3, 0);
        @(negedge clk); check("step_write", int'(state), 4, 0);
        @(negedge clk); check("step_read2", int'(state), 2, 0);
        start_i = 1'b1; x0_re_i = 777;
        repeat (2) @(negedge clk);
        start_i = 1'b0; x0_re_i = 0;
        wait_done(t_rise);
        check("ready_latency", int'((t_rise - t_start) / 10), 1 + 16 + 96, 0);

        // Tone at bin 1/15 plus address check at stage 1, butterfly 3
        for (int i = 0; i < N; i++) begin
            samp_re[i] = tone_tbl[bitrev4(i)]; samp_im[i] = 0;
            exp_re[i] = (i == 1 || i == 15) ? 32768 : 0; exp_im[i] = 0;
        end
        push_expected(16);
        load_samples(t_start);
        repeat (34) @(negedge clk);
        check("addr_state", int'(state), 2, 0);
        check("addr_x0", int'(bram_addr_x0), 5, 0);
        check("addr_x1", int'(bram_addr_x1), 7, 0);
        check("addr_tw", int'(twiddle_addr), 4, 0);
        check("addr_w_re", int'($signed(w_re)), 0, 0);
        check("addr_w_im", int'($signed(w_im)), -4096, 0);
        check("addr_en", int'(bram_x0_en & bram_x1_en), 1, 0);
        wait_done(t_rise);

        // Reset during stage 2, then a fresh impulse run
        for (int i = 0; i < N; i++) begin
            samp_re[i] = 100; samp_im[i] = 0;
        end
        load_samples(t_start);
        repeat (52) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        check("mid_rst_state", int'(state), 0, 0);
        check("mid_rst_ready", int'(fft_ready_o), 0, 0);
        check("mid_rst_x1_re_o", x1_re_o, 0, 0);
        check("mid_rst_x0_ram", x0_re_ram, 0, 0);
        check("mid_rst_X0_bf", X0_re_bf, 0, 0);
        check("mid_rst_addr_x1", int'(bram_addr_x1), 0, 0);
        check("mid_rst_en", int'(bram_x0_en | bram_x1_en), 0, 0);
        rstn = 1'b0;
        set_impulse();
        push_expected(0);
        load_samples(t_start);
        wait_done(t_rise);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fft_radix2_core.md
Name: fft_radix2_core

Overview:
- Iterative in-place radix-2 decimation-in-time FFT, N complex points (default 16).
- Loads N samples, already in bit-reversed order, from the x0 input lane, one sample per cycle.
- Runs log2(N) butterfly stages over internal storage using a fixed twiddle ROM, then streams the result out.
- Exposes internal datapath signals as debug ports for bring-up benches.

Parameters:
- N, 16, FFT length; power of two, 4..1024.

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  reset; synchronous, active-high (asserted = 1, despite the name).
- x0_re_i, x0_im_i  in  32 each  load sample, signed two's complement.
- x1_re_i, x1_im_i  in  32 each  reserved, ignored.
- start_i  in  1  load strobe.
- fft_ready_o  out  1  high while result pairs are valid.
- x0_re_o, x0_im_o, x1_re_o, x1_im_o  out  32 each  result pair.
- x0_re_ram, x0_im_ram, x1_re_ram, x1_im_ram  out  32 each  registered butterfly operands read from storage.
- X0_re_bf, X0_im_bf, X1_re_bf, X1_im_bf  out  32 each  registered butterfly results.
- w_re, w_im  out  14 each  current twiddle, signed Q1.12.
- bram_addr_x0, bram_addr_x1  out  clog2(N) each  butterfly pair addresses.
- twiddle_addr  out  clog2(N/2)  twiddle ROM index.
- bram_x0_en, bram_x1_en  out  1 each  storage access enables (read or write).
- state  out  4  FSM state code.

Behaviour:
- Reset: all outputs 0, state=IDLE, all counters 0. Storage contents are not cleared. Reset mid-operation aborts the run and returns to IDLE on the next edge.
- FSM encodings:
  - IDLE=0, LOAD=1, READ=2, CALC=3, WRITE=4, OUT=5.
  - Unused codes go to IDLE.
- Load timing:
  - start_i is registered (start_d).
  - IDLE→LOAD when start_d=1.
  - Every cycle start_d=1, write {x0_re_i,x0_im_i} to storage[load_cnt] and increment load_cnt. The sample present one cycle after start_i is first sampled is stored at address 0.
  - After N writes, go to READ with stage=0, bfly=0.
  - If start_d drops early, remain in LOAD until N samples are written.
  - start_i is ignored outside IDLE and LOAD.
- Address generation (stage s, span=2^s, butterfly b in 0..N/2-1):
  - pos = b mod span, grp = b>>s.
  - a0 = grp*2*span + pos, a1 = a0 + span.
  - twiddle_addr = pos << (log2N-1-s).
- Twiddle ROM:
  - w_re = round(4096*cos(2πk/N)).
  - w_im = round(-4096*sin(2πk/N)).
  - k=0 gives (4096, 0).
- Butterfly step, 3 cycles:
  - READ: addresses valid and enables high; operands registered into *_ram.
  - CALC: t = (x1*w) arithmetic-shifted right by 12 (truncation toward −inf), complex multiply. X0 = x0 + t, X1 = x0 − t, 32-bit wrap-around, no scaling, no saturation. Results registered into *_bf.
  - WRITE: write *_bf to a0/a1, enables high.
  - Then next butterfly. After b=N/2-1, stage++. After stage log2N-1 completes, go to OUT.
- Compute latency: log2N*(N/2)*3 cycles (96 for N=16).
- OUT:
  - For k = 0..N/2-1, one pair per cycle: x0_o = X[2k], x1_o = X[2k+1], natural order, fft_ready_o=1.
  - Then fft_ready_o=0 and state=IDLE.
  - Output registers hold their last value after OUT.
- Enables are low in IDLE and OUT except during storage reads.

Decomposition:
- Shared package holds:
  - N default and the widths DATA_W=32, TW_W=14, TW_FRAC=12.
  - FSM state encodings.
  - Twiddle ROM constant function.
- One sub-module, fft_butterfly_unit: combinational complex multiply-add with shift and wrap rules.

Test Plan:
- Impulse: x[0]=1000, all other samples 0 (bit-reversed load) → all 16 X = (1000, 0); fft_ready_o high exactly 8 cycles; state returns to 0.
- DC: all samples 100 → X[0]=(1600, 0), X[1..15]=(0, 0).
- Tone: x[n]=round(4096*cos(2πn/16)) → X[1] and X[15] ≈ (32768, 0) within ±16; all other bins within ±16 of 0.
- Timing: start_i high for 16 cycles → fft_ready_o rises exactly 1+16+96 cycles after the first start_d, with 3-cycle READ/CALC/WRITE steps visible on state; second start_i pulse during compute has no effect.
- Reset mid-compute: assert rstn during stage 2 → next cycle all outputs 0, state=0; a fresh load then yields the correct impulse result.
- Address check, stage 1, b=3 → bram_addr_x0=5, bram_addr_x1=7, twiddle_addr=4, w=(0, −4096).
